// File: rtl/scr1_dmem_lane_bridge_if.sv
// LSU-side and memory-side signal bundle for scr1_dmem_lane_bridge.
// slave = the bridge; master = whoever drives the LSU request and models memory.
interface scr1_dmem_lane_bridge_if #(
  parameter int AWIDTH = 32
);
  logic              lsu_req_i;
  logic              lsu_cmd_i;
  logic [1:0]        lsu_width_i;
  logic [AWIDTH-1:0] lsu_addr_i;
  logic [31:0]       lsu_wdata_i;
  logic              lsu_req_ack_o;
  logic [31:0]       lsu_rdata_o;
  logic [1:0]        lsu_resp_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [AWIDTH-1:0] mem_addr_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_req_ack_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;
  logic              mem_rerr_i;

  modport slave (
    input  lsu_req_i, lsu_cmd_i, lsu_width_i, lsu_addr_i, lsu_wdata_i,
    output lsu_req_ack_o, lsu_rdata_o, lsu_resp_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  mem_req_ack_i, mem_rvalid_i, mem_rdata_i, mem_rerr_i
  );

  modport master (
    output lsu_req_i, lsu_cmd_i, lsu_width_i, lsu_addr_i, lsu_wdata_i,
    input  lsu_req_ack_o, lsu_rdata_o, lsu_resp_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output mem_req_ack_i, mem_rvalid_i, mem_rdata_i, mem_rerr_i
  );
endinterface

// File: rtl/scr1_dmem_lane_bridge.sv
// LSU -> 32-bit byte-enabled DMEM bridge with in-order response tracking.
// Optional misaligned-access trap: define SCR1_DMEM_BRIDGE_MSLGN_CHK_EN.

// One byte lane: write enable/data steering and right-aligned read extraction.
module scr1_dmem_lane_bridge_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  req_width,
  input  logic [1:0]  req_off,
  input  logic [7:0]  wb_byte,
  input  logic [7:0]  wb_hword,
  input  logic [7:0]  wb_word,
  output logic        be,
  output logic [7:0]  wbyte,
  input  logic [1:0]  rsp_width,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rsp_rdata,
  output logic [7:0]  rbyte
);
  localparam logic [1:0] LN = 2'(LANE);

  logic [2:0] src;
  logic       keep;

  always_comb begin
    be    = 1'b1;
    wbyte = wb_word;
    case (req_width)
      2'd0: begin be = (req_off == LN);       wbyte = wb_byte;  end
      2'd1: begin be = (req_off[1] == LN[1]); wbyte = wb_hword; end
      default: ;
    endcase
  end

  // Lane LANE of the result is byte (LANE+off) of the bus word, if inside the access width.
  assign src   = {1'b0, rsp_off} + {1'b0, LN};
  assign keep  = (LN == 2'd0) | ((LN == 2'd1) & (rsp_width != 2'd0)) | rsp_width[1];
  assign rbyte = (keep & ~src[2]) ? rsp_rdata[{src[1:0], 3'b000} +: 8] : 8'h00;
endmodule

module scr1_dmem_lane_bridge #(
  parameter int OUTST_DEPTH = 2,
  parameter int AWIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  scr1_dmem_lane_bridge_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int PW = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;
  localparam int CW = $clog2(OUTST_DEPTH + 1);

  localparam logic [1:0] RESP_IDLE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ER   = 2'd2;

  typedef struct packed {
    logic       cmd;
    logic [1:0] width;
    logic [1:0] off;
    logic       lerr;
  } trk_t;

  trk_t          fifo_q [OUTST_DEPTH];
  trk_t          head, push_ent;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop, fwd, mslgn;
  logic          pop_err;
  logic [31:0]   pop_rdata;
  logic [1:0]    req_off;
  logic [1:0]    resp_q;
  logic [31:0]   rdata_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTST_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---------------- request path (combinational) ----------------
  always_comb begin
    case (bus.lsu_width_i)
      2'd0:    req_off = bus.lsu_addr_i[1:0];
      2'd1:    req_off = {bus.lsu_addr_i[1], 1'b0};
      default: req_off = 2'b00;
    endcase
  end

`ifdef SCR1_DMEM_BRIDGE_MSLGN_CHK_EN
  assign mslgn = (bus.lsu_width_i == 2'd1) ? bus.lsu_addr_i[0]
                                           : (bus.lsu_width_i[1] & (bus.lsu_addr_i[1:0] != 2'b00));
`else
  assign mslgn = 1'b0;
`endif

  assign full  = (count == CW'(OUTST_DEPTH));
  assign empty = (count == '0);
  assign fwd   = bus.lsu_req_i & ~full & rst_n & ~mslgn;
  // Misaligned requests never reach memory; they are acked locally.
  assign push  = fwd ? bus.mem_req_ack_i : (bus.lsu_req_i & ~full & rst_n & mslgn);

  assign bus.mem_req_o     = fwd;
  assign bus.lsu_req_ack_o = push;
  assign bus.mem_we_o      = bus.lsu_cmd_i;
  assign bus.mem_addr_o    = {bus.lsu_addr_i[AWIDTH-1:2], 2'b00};

  assign push_ent = '{cmd: bus.lsu_cmd_i, width: bus.lsu_width_i, off: req_off, lerr: mslgn};

  logic [NUM_LANES-1:0]      lane_be;
  logic [NUM_LANES-1:0][7:0] lane_wb, lane_rb, rep_b, rep_h, rep_w;

  assign rep_b = {NUM_LANES{bus.lsu_wdata_i[7:0]}};
  assign rep_h = {(NUM_LANES/2){bus.lsu_wdata_i[15:0]}};
  assign rep_w = bus.lsu_wdata_i;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    scr1_dmem_lane_bridge_lane #(.LANE(g)) u_lane (
      .req_width (bus.lsu_width_i),
      .req_off   (req_off),
      .wb_byte   (rep_b[g]),
      .wb_hword  (rep_h[g]),
      .wb_word   (rep_w[g]),
      .be        (lane_be[g]),
      .wbyte     (lane_wb[g]),
      .rsp_width (head.width),
      .rsp_off   (head.off),
      .rsp_rdata (pop_rdata),
      .rbyte     (lane_rb[g])
    );
  end

  assign bus.mem_be_o    = lane_be;
  assign bus.mem_wdata_o = lane_wb;

  // ---------------- tracking FIFO ----------------
  assign head = fifo_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- response selection ----------------
`ifdef SCR1_DMEM_BRIDGE_MSLGN_CHK_EN
  logic        skid_v, skid_err, skid_ld, pop_mem, head_local;
  logic [31:0] skid_rdata;

  // A memory response landing while a local-error entry is at the head is
  // parked for one cycle so the local entry completes first.
  assign head_local = ~empty & head.lerr;
  assign pop_mem    = ~empty & ~head.lerr & (skid_v | bus.mem_rvalid_i);
  assign pop        = head_local | pop_mem;
  assign pop_err    = skid_v ? skid_err   : bus.mem_rerr_i;
  assign pop_rdata  = skid_v ? skid_rdata : bus.mem_rdata_i;
  assign skid_ld    = bus.mem_rvalid_i & ~empty & (head.lerr | skid_v);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_v     <= 1'b0;
      skid_err   <= 1'b0;
      skid_rdata <= '0;
    end else if (skid_ld) begin
      skid_v     <= 1'b1;
      skid_err   <= bus.mem_rerr_i;
      skid_rdata <= bus.mem_rdata_i;
    end else if (pop_mem) begin
      skid_v     <= 1'b0;
    end
  end

  a_skid_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(skid_v & head_local & bus.mem_rvalid_i))
    else $warning("memory response dropped: skid already occupied");
`else
  assign pop       = bus.mem_rvalid_i & ~empty;
  assign pop_err   = bus.mem_rerr_i;
  assign pop_rdata = bus.mem_rdata_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q  <= RESP_IDLE;
      rdata_q <= '0;
    end else if (pop) begin
      resp_q  <= (head.lerr | pop_err) ? RESP_ER : RESP_OK;
      rdata_q <= (head.cmd | head.lerr) ? 32'h0 : lane_rb;
    end else begin
      resp_q  <= RESP_IDLE;
    end
  end

  assign bus.lsu_resp_o  = resp_q;
  assign bus.lsu_rdata_o = rdata_q;

  a_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.mem_rvalid_i & empty))
    else $warning("mem_rvalid_i with no outstanding entry ignored");
endmodule

// File: tb/tb_scr1_dmem_lane_bridge.sv
// Directed bench for scr1_dmem_lane_bridge: vector table plus hand-written
// sequences for back-pressure, stray responses, reset and misalignment.
module tb_scr1_dmem_lane_bridge;
  localparam int AW    = 32;
  localparam int DEPTH = 2;

  localparam logic [1:0] IDLE = 2'd0, OK = 2'd1, ER = 2'd2;

  typedef struct {
    logic        cmd;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    logic        rerr;
    logic        lerr;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic [1:0]  e_resp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scr1_dmem_lane_bridge_if #(.AWIDTH(AW)) bus ();

  scr1_dmem_lane_bridge #(.OUTST_DEPTH(DEPTH), .AWIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic cmd, input logic [1:0] w, input logic [31:0] a,
                           input logic [31:0] wd);
    bus.lsu_req_i   = 1'b1;
    bus.lsu_cmd_i   = cmd;
    bus.lsu_width_i = w;
    bus.lsu_addr_i  = a;
    bus.lsu_wdata_i = wd;
  endtask

  function automatic vec_t mk(input logic cmd, input logic [1:0] w, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] mr, input logic rerr,
                              input logic mis, input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd, input logic [31:0] erd, input logic [1:0] ers);
    vec_t v;
    v = '{cmd, w, a, wd, mr, rerr, 1'b0, ea, ebe, ewd, erd, ers};
`ifdef SCR1_DMEM_BRIDGE_MSLGN_CHK_EN
    v.lerr = mis;
`else
    v.lerr = 1'b0 & mis;
`endif
    return v;
  endfunction

  initial begin
    vec_t v;

    bus.lsu_req_i = 1'b1; bus.lsu_cmd_i = 1'b0; bus.lsu_width_i = 2'd2;
    bus.lsu_addr_i = '0;  bus.lsu_wdata_i = '0;
    bus.mem_req_ack_i = 1'b1; bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = '0; bus.mem_rerr_i = 1'b0;

    //  cmd w   addr     wdata        mrdata       rerr mis  e_addr   be      e_wdata      e_rdata      resp
    tbl.push_back(mk(1, 0, 32'h103, 32'h000000A5, 32'h0,        0, 0, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0,        OK));
    tbl.push_back(mk(0, 1, 32'h202, 32'h12345678, 32'hBEEF1234, 0, 0, 32'h200, 4'b1100, 32'h56785678, 32'h0000BEEF, OK));
    tbl.push_back(mk(0, 2, 32'h304, 32'h12345678, 32'hDEADBEEF, 0, 0, 32'h304, 4'b1111, 32'h12345678, 32'hDEADBEEF, OK));
    tbl.push_back(mk(0, 0, 32'h401, 32'hCAFE00C3, 32'h11223344, 0, 0, 32'h400, 4'b0010, 32'hC3C3C3C3, 32'h00000033, OK));
    tbl.push_back(mk(1, 1, 32'h503, 32'h0000BEEF, 32'h0,        0, 1, 32'h500, 4'b1100, 32'hBEEFBEEF, 32'h0,        OK));
    tbl.push_back(mk(0, 2, 32'h600, 32'h0,        32'hFFFFFFFF, 1, 0, 32'h600, 4'b1111, 32'h0,        32'hFFFFFFFF, ER));
    tbl.push_back(mk(1, 3, 32'h702, 32'h89ABCDEF, 32'h0,        0, 1, 32'h700, 4'b1111, 32'h89ABCDEF, 32'h0,        OK));
    tbl.push_back(mk(0, 0, 32'h800, 32'h0000005A, 32'hAABBCCDD, 0, 0, 32'h800, 4'b0001, 32'h5A5A5A5A, 32'h000000DD, OK));
    tbl.push_back(mk(0, 1, 32'h901, 32'h00001234, 32'hAABBCCDD, 0, 1, 32'h900, 4'b0011, 32'h12341234, 32'h0000CCDD, OK));
    tbl.push_back(mk(1, 0, 32'hA02, 32'h0000007E, 32'h0,        1, 0, 32'hA00, 4'b0100, 32'h7E7E7E7E, 32'h0,        ER));

    // Reset state, with a live request that must not leak out.
    #1;
    chk("rst mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("rst req_ack", 32'(bus.lsu_req_ack_o), 32'h0);
    chk("rst resp", 32'(bus.lsu_resp_o), 32'(IDLE));
    chk("rst rdata", bus.lsu_rdata_o, 32'h0);
    chk("rst count", 32'(dut.count), 32'h0);
    #11 rst_n = 1'b1;
    bus.lsu_req_i = 1'b0;
    step();

    foreach (tbl[i]) begin
      v = tbl[i];
      drive_req(v.cmd, v.width, v.addr, v.wdata);
      bus.mem_req_ack_i = 1'b1;
      #1;
      chk($sformatf("v%0d mem_req", i), 32'(bus.mem_req_o), 32'(!v.lerr));
      chk($sformatf("v%0d req_ack", i), 32'(bus.lsu_req_ack_o), 32'h1);
      if (!v.lerr) begin
        chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we_o), 32'(v.cmd));
        chk($sformatf("v%0d mem_addr", i), bus.mem_addr_o, v.e_addr);
        chk($sformatf("v%0d mem_be", i), 32'(bus.mem_be_o), 32'(v.e_be));
        chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata_o, v.e_wdata);
      end
      step();
      bus.lsu_req_i = 1'b0;
      bus.mem_req_ack_i = 1'b0;
      bus.mem_rvalid_i = !v.lerr;
      bus.mem_rdata_i = v.mrdata;
      bus.mem_rerr_i = v.rerr;
      step();
      bus.mem_rvalid_i = 1'b0;
      chk($sformatf("v%0d resp", i), 32'(bus.lsu_resp_o), v.lerr ? 32'(ER) : 32'(v.e_resp));
      chk($sformatf("v%0d rdata", i), bus.lsu_rdata_o, v.lerr ? 32'h0 : v.e_rdata);
      chk($sformatf("v%0d count", i), 32'(dut.count), 32'h0);
      step();
      chk($sformatf("v%0d resp idle", i), 32'(bus.lsu_resp_o), 32'(IDLE));
      chk($sformatf("v%0d rdata hold", i), bus.lsu_rdata_o, v.lerr ? 32'h0 : v.e_rdata);
    end

    // Three back-to-back byte reads into a 2-deep tracker.
    bus.mem_req_ack_i = 1'b1;
    drive_req(0, 0, 32'h10, 32'h0); #1;
    chk("bb0 mem_req", 32'(bus.mem_req_o), 32'h1);
    chk("bb0 req_ack", 32'(bus.lsu_req_ack_o), 32'h1);
    step();
    drive_req(0, 0, 32'h11, 32'h0); #1;
    chk("bb1 req_ack", 32'(bus.lsu_req_ack_o), 32'h1);
    step();
    drive_req(0, 0, 32'h12, 32'h0); #1;
    chk("bb2 full mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("bb2 full req_ack", 32'(bus.lsu_req_ack_o), 32'h0);
    chk("bb2 count", 32'(dut.count), 32'h2);
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h44332211; bus.mem_rerr_i = 1'b0;
    #1;
    chk("bb2 pop no free", 32'(bus.mem_req_o), 32'h0);
    step();
    chk("bb r0 resp", 32'(bus.lsu_resp_o), 32'(OK));
    chk("bb r0 rdata", bus.lsu_rdata_o, 32'h11);
    chk("bb2 mem_req", 32'(bus.mem_req_o), 32'h1);
    chk("bb2 req_ack", 32'(bus.lsu_req_ack_o), 32'h1);
    step();
    chk("bb push+pop count", 32'(dut.count), 32'h1);
    chk("bb r1 resp", 32'(bus.lsu_resp_o), 32'(OK));
    chk("bb r1 rdata", bus.lsu_rdata_o, 32'h22);
    bus.lsu_req_i = 1'b0;
    step();
    bus.mem_rvalid_i = 1'b0;
    chk("bb r2 resp", 32'(bus.lsu_resp_o), 32'(OK));
    chk("bb r2 rdata", bus.lsu_rdata_o, 32'h33);
    chk("bb count", 32'(dut.count), 32'h0);

    // Stray response with nothing outstanding.
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hFFFFFFFF; bus.mem_rerr_i = 1'b1;
    step();
    bus.mem_rvalid_i = 1'b0; bus.mem_rerr_i = 1'b0;
    chk("stray resp", 32'(bus.lsu_resp_o), 32'(IDLE));
    chk("stray rdata", bus.lsu_rdata_o, 32'h33);
    chk("stray count", 32'(dut.count), 32'h0);

    // Reset with two reads outstanding.
    drive_req(0, 2, 32'h20, 32'h0); step();
    drive_req(0, 2, 32'h24, 32'h0); step();
    chk("pre-rst count", 32'(dut.count), 32'h2);
    rst_n = 1'b0; #1;
    chk("mid-rst count", 32'(dut.count), 32'h0);
    chk("mid-rst resp", 32'(bus.lsu_resp_o), 32'(IDLE));
    chk("mid-rst rdata", bus.lsu_rdata_o, 32'h0);
    chk("mid-rst mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("mid-rst req_ack", 32'(bus.lsu_req_ack_o), 32'h0);
    bus.lsu_req_i = 1'b0;
    #3 rst_n = 1'b1;
    step();
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h12345678;
    step();
    bus.mem_rvalid_i = 1'b0;
    chk("late resp", 32'(bus.lsu_resp_o), 32'(IDLE));
    chk("late count", 32'(dut.count), 32'h0);

`ifdef SCR1_DMEM_BRIDGE_MSLGN_CHK_EN
    // Misaligned word read queued behind a pending read completes after it.
    bus.mem_req_ack_i = 1'b1;
    drive_req(0, 0, 32'h40, 32'h0); step();
    drive_req(0, 2, 32'h301, 32'h0); #1;
    chk("mis mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("mis req_ack", 32'(bus.lsu_req_ack_o), 32'h1);
    step();
    bus.lsu_req_i = 1'b0;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h000000AB; bus.mem_rerr_i = 1'b0;
    step();
    bus.mem_rvalid_i = 1'b0;
    chk("mis prior resp", 32'(bus.lsu_resp_o), 32'(OK));
    chk("mis prior rdata", bus.lsu_rdata_o, 32'hAB);
    step();
    chk("mis local resp", 32'(bus.lsu_resp_o), 32'(ER));
    chk("mis local rdata", bus.lsu_rdata_o, 32'h0);
    chk("mis count", 32'(dut.count), 32'h0);
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/scr1_dmem_lane_bridge.md
Name: scr1_dmem_lane_bridge

Overview:
Sits directly downstream of the pipeline LSU on its DMEM port and converts LSU byte/halfword/word requests into a 32-bit byte-enabled memory bus. It replicates write data across lanes and generates byte enables. It tracks outstanding transactions in order, then right-aligns and zero-fills read data so the LSU can sign- or zero-extend from bit 0. Responses go back on the LSU's req_ack/resp protocol.

Parameters:
OUTST_DEPTH, 2, max outstanding memory transactions (tracking FIFO depth, power of 2, >=1)
AWIDTH, 32, address width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
lsu_req_i  in  1  LSU request
lsu_cmd_i  in  1  0=READ, 1=WRITE
lsu_width_i  in  2  0=BYTE, 1=HWORD, 2=WORD (3 treated as WORD)
lsu_addr_i  in  AWIDTH  byte address
lsu_wdata_i  in  32  store data, right-aligned
lsu_req_ack_o  out  1  request accepted this cycle
lsu_rdata_o  out  32  right-aligned load data
lsu_resp_o  out  2  0=IDLE, 1=RDY_OK, 2=RDY_ER
mem_req_o  out  1  memory request
mem_we_o  out  1  write enable
mem_addr_o  out  AWIDTH  word address, [1:0] forced to 0
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-replicated write data
mem_req_ack_i  in  1  memory accepted request
mem_rvalid_i  in  1  in-order response (reads and writes)
mem_rdata_i  in  32  read data, valid with rvalid
mem_rerr_i  in  1  response error, valid with rvalid

Behaviour:
- Reset: lsu_resp_o=IDLE, lsu_rdata_o=0, tracking FIFO empty (count=0, pointers=0). mem_req_o=0 and lsu_req_ack_o=0 while in reset.
- Request path is combinational. mem_req_o = lsu_req_i & ~full. lsu_req_ack_o = mem_req_ack_i & mem_req_o. mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o are derived from the lsu_* inputs in the same cycle.
- Offset off=lsu_addr_i[1:0]. Byte: be=4'b0001<<off, wdata={4{wdata[7:0]}}. Hword: be=4'b0011<<{off[1],0}, wdata={2{wdata[15:0]}}, off[0] ignored. Word: be=4'b1111, off ignored.
- On accept, push {cmd, width, effective off} into the FIFO.
- full: count==OUTST_DEPTH, from the registered count only. A pop in the same cycle does not free a slot for a push.
- Simultaneous push and pop: count unchanged, both pointers advance.
- On mem_rvalid_i with FIFO non-empty: pop the head and register the response, giving 1-cycle latency to the LSU.
  - Next cycle: lsu_resp_o = mem_rerr_i ? RDY_ER : RDY_OK.
  - Read: lsu_rdata_o = (mem_rdata_i >> 8*off), masked to 8/16/32 bits per width with upper bits zero.
  - Write: lsu_rdata_o=0.
  - In any cycle without a pop: lsu_resp_o=IDLE and lsu_rdata_o holds its last value.
- mem_rvalid_i with FIFO empty: ignored; no response and no state change. Flagged by a simulation assertion.
- Pointers wrap modulo OUTST_DEPTH.
- Asynchronous reset mid-transaction discards all outstanding entries. Late memory responses after reset fall under the empty-FIFO rule.

Optional Feature:
Macro SCR1_DMEM_BRIDGE_MSLGN_CHK_EN.
- Defined: a misaligned request (hword with addr[0]=1, or word with addr[1:0]!=0) is not forwarded. mem_req_o=0 for it, lsu_req_ack_o=~full, and an entry with a local-error flag is pushed.
- When a local-error entry reaches the FIFO head, it pops without waiting for mem_rvalid_i. The next cycle gives RDY_ER with rdata=0.
- Ordering is preserved: earlier outstanding entries complete first.
- If mem_rvalid_i arrives while a local entry is at the head, it waits a cycle; the local entry pops first.
- Undefined: no check; offset low bits are ignored as described in Behaviour.

Test Plan:
- Byte write addr=0x103, wdata=0x000000A5, ack=1 -> mem_addr=0x100, be=4'b1000, mem_wdata=0xA5A5A5A5; rvalid next cycle -> RDY_OK one cycle later.
- Hword read addr=0x202, mem_rdata=0xBEEF1234 -> lsu_rdata_o=0x0000BEEF, RDY_OK one cycle after rvalid.
- OUTST_DEPTH=2, three back-to-back reads with no rvalid -> first two acked, third sees mem_req_o=0 until a pop. Responses return in issue order with the correct per-entry offsets.
- rvalid with mem_rerr_i=1 on a word read -> RDY_ER, count decremented.
- rvalid while FIFO empty -> lsu_resp_o stays IDLE, count stays 0. Reset asserted with 2 outstanding -> count=0 and resp IDLE immediately.
- With SCR1_DMEM_BRIDGE_MSLGN_CHK_EN: word read addr=0x301 behind one pending read -> mem_req_o=0 and ack=1. After the pending rvalid gives RDY_OK, the next cycle gives RDY_ER.
